// File: rtl/counter_pkg.sv
// Shared counter types and the next-count helper, used by updown_counter and future timers.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [31:0] value;
        logic        wrap;
    } count_res_t;

    // Values are carried in 32 bits so any WIDTH up to 32 can share this helper.
    function automatic count_res_t next_count(input logic [31:0] value,
                                              input logic [31:0] max,
                                              input dir_e        up,
                                              input mode_e       sat);
        count_res_t res;
        res.value = value;
        res.wrap  = 1'b0;
        if (up == DIR_UP) begin
            if (value >= max) begin
                if (sat == MODE_SAT) begin
                    res.value = max;
                end else begin
                    res.value = '0;
                    res.wrap  = 1'b1;
                end
            end else begin
                res.value = value + 32'd1;
            end
        end else begin
            if (value == '0) begin
                if (sat == MODE_SAT) begin
                    res.value = '0;
                end else begin
                    res.value = max;
                    res.wrap  = 1'b1;
                end
            end else begin
                res.value = value - 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: passes one enabled cycle out of every PRESCALE enabled cycles.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        step_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                step_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, wrap/saturate, tc pulse and sticky overflow.
// Define UPDOWN_COUNTER_PRESCALER_EN to add the PRESCALE enable divider and tick output.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  MAX_COUNT = '1
`ifdef UPDOWN_COUNTER_PRESCALER_EN
    ,
    parameter int unsigned       PRESCALE  = 4
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
`ifdef UPDOWN_COUNTER_PRESCALER_EN
    output logic             tick,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             overflow
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    count_res_t       step_res;
    logic             unused_hi;

`ifdef UPDOWN_COUNTER_PRESCALER_EN
    logic tick_q, tick_d;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_i  (clock),
        .reset_i  (reset),
        .clear_i  (load),
        .enable_i (enable),
        .step_o   (step)
    );

    always_comb tick_d = step && !load;

    always_ff @(posedge clock) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= tick_d;
    end

    assign tick = tick_q;
`else
    assign step = enable;
`endif

    // Upper helper bits are always zero for WIDTH < 32.
    assign unused_hi = ^step_res.value;

    always_comb begin
        step_res = next_count(32'(out_q), 32'(MAX_COUNT), dir_e'(up), mode_e'(saturate));
        out_d    = out_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        if (clear_flag) ovf_d = 1'b0;
        if (load) begin
            out_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end else if (step) begin
            out_d = step_res.value[WIDTH-1:0];
            tc_d  = up ? (out_q == MAX_COUNT) : (out_q == '0);
            if (step_res.wrap) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out      = out_q;
    assign tc       = tc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter (WIDTH=4, MAX_COUNT=9); prescaler sequence when UPDOWN_COUNTER_PRESCALER_EN is defined.
module tb_updown_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       saturate = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       clear_flag = 1'b0;
    logic [3:0] out;
    logic       tc;
    logic       overflow;
    logic       tick_obs;

    typedef struct {
        string      name;
        logic [3:0] out;
        logic       tc;
        logic       ovf;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

`ifdef UPDOWN_COUNTER_PRESCALER_EN
    logic tick;
    assign tick_obs = tick;
    updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .PRESCALE(3)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .load(load), .load_value(load_value), .clear_flag(clear_flag),
        .tick(tick), .out(out), .tc(tc), .overflow(overflow)
    );
`else
    assign tick_obs = 1'b0;
    updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .load(load), .load_value(load_value), .clear_flag(clear_flag),
        .out(out), .tc(tc), .overflow(overflow)
    );
`endif

    // Drive one edge's inputs and queue the outputs expected after that edge.
    task automatic vec(input string name, input logic r, input logic en, input logic u,
                       input logic s, input logic ld, input logic [3:0] lv, input logic clr,
                       input logic [3:0] eo, input logic etc, input logic eov, input logic etk);
        exp_t e;
        @(negedge clock);
        reset = r; enable = en; up = u; saturate = s;
        load = ld; load_value = lv; clear_flag = clr;
        e.name = name; e.out = eo; e.tc = etc; e.ovf = eov; e.tick = etk;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({out, tc, overflow, tick_obs} !== {e.out, e.tc, e.ovf, e.tick}) begin
                    miscompares++;
                    $display("FAIL %s: got out=%0d tc=%0b ovf=%0b tick=%0b, expected out=%0d tc=%0b ovf=%0b tick=%0b",
                             e.name, out, tc, overflow, tick_obs, e.out, e.tc, e.ovf, e.tick);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned waited;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
        vec("reset",   1,0,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("pre_e1",  0,1,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("pre_e2",  0,1,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("pre_e3",  0,1,1,0,0,4'd0,0, 4'd1,0,0,1);
        vec("pre_e4",  0,1,1,0,0,4'd0,0, 4'd1,0,0,0);
        vec("pre_e5",  0,1,1,0,0,4'd0,0, 4'd1,0,0,0);
        vec("pre_e6",  0,1,1,0,0,4'd0,0, 4'd2,0,0,1);
        vec("pre_e7",  0,1,1,0,0,4'd0,0, 4'd2,0,0,0);
        vec("pre_e8",  0,1,1,0,0,4'd0,0, 4'd2,0,0,0);
        vec("pre_e9",  0,1,1,0,0,4'd0,0, 4'd3,0,0,1);
        vec("pre_idle",0,0,1,0,0,4'd0,0, 4'd3,0,0,0);
        vec("pre_p1",  0,1,1,0,0,4'd0,0, 4'd3,0,0,0);
        vec("pre_load",0,0,1,0,1,4'd0,0, 4'd0,0,0,0);
        vec("pre_l1",  0,1,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("pre_l2",  0,1,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("pre_l3",  0,1,1,0,0,4'd0,0, 4'd1,0,0,1);
`else
        vec("reset",   1,0,1,0,0,4'd0,0, 4'd0,0,0,0);
        for (int i = 1; i <= 9; i++)
            vec($sformatf("up_%0d", i), 0,1,1,0,0,4'd0,0, 4'(i),0,0,0);
        vec("up_wrap", 0,1,1,0,0,4'd0,0, 4'd0,1,1,0);
        vec("up_11",   0,1,1,0,0,4'd0,0, 4'd1,0,1,0);
        vec("up_12",   0,1,1,0,0,4'd0,0, 4'd2,0,1,0);
        vec("clear",   0,0,1,0,0,4'd0,1, 4'd2,0,0,0);
        vec("load0",   0,0,1,0,1,4'd0,0, 4'd0,0,0,0);
        vec("dn_wrap", 0,1,0,0,0,4'd0,0, 4'd9,1,1,0);
        vec("dn_clr",  0,0,0,0,0,4'd0,1, 4'd9,0,0,0);
        vec("hold",    0,0,1,0,0,4'd0,0, 4'd9,0,0,0);
        vec("sat_ld8", 0,0,1,1,1,4'd8,0, 4'd8,0,0,0);
        vec("sat_1",   0,1,1,1,0,4'd0,0, 4'd9,0,0,0);
        vec("sat_2",   0,1,1,1,0,4'd0,0, 4'd9,1,0,0);
        vec("sat_3",   0,1,1,1,0,4'd0,0, 4'd9,1,0,0);
        vec("sat_ld0", 0,0,0,1,1,4'd0,0, 4'd0,0,0,0);
        vec("sat_dn",  0,1,0,1,0,4'd0,0, 4'd0,1,0,0);
        vec("clamp15", 0,1,1,0,1,4'd15,0, 4'd9,0,0,0);
        vec("load3",   0,1,1,0,1,4'd3,0, 4'd3,0,0,0);
        vec("ld9",     0,0,1,0,1,4'd9,0, 4'd9,0,0,0);
        vec("clr_wrap",0,1,1,0,0,4'd0,1, 4'd0,1,1,0);
        vec("ld5_ovf", 0,0,1,0,1,4'd5,0, 4'd5,0,1,0);
        vec("rst_load",1,1,1,0,1,4'd5,0, 4'd0,0,0,0);
        vec("step1",   0,1,1,0,0,4'd0,0, 4'd1,0,0,0);
        vec("rst_mid", 1,1,1,0,0,4'd0,0, 4'd0,0,0,0);
        vec("ld4",     0,0,1,0,1,4'd4,0, 4'd4,0,0,0);
        vec("dir_dn",  0,1,0,0,0,4'd0,0, 4'd3,0,0,0);
        vec("dir_up",  0,1,1,0,0,4'd0,0, 4'd4,0,0,0);
`endif
        @(negedge clock);
        enable = 1'b0; load = 1'b0; reset = 1'b0; clear_flag = 1'b0;
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
